// File: rtl/branch_pkg.sv
// branch_pkg: branch condition codes, FSM encoding and compare-flag constants
package branch_pkg;
  localparam logic [2:0] BR_ALWAYS = 3'd0;
  localparam logic [2:0] BR_LT = 3'd1;
  localparam logic [2:0] BR_GE = 3'd2;
  localparam logic [2:0] BR_EQ = 3'd3;
  localparam logic [2:0] BR_NE = 3'd4;
  localparam logic [15:0] FLAG_LT_MASK = 16'hFFFF;
  localparam logic [15:0] FLAG_GE_MASK = 16'h0000;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE, S_FLUSH} state_t;
  function automatic logic flag_ok(input logic [15:0] m);
    return m == FLAG_LT_MASK || m == FLAG_GE_MASK;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch decision from cond code and lt/eq flags
// Ports: cond (3-bit code), lt, eq in; taken out (reserved codes never taken).
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       lt,
  input  logic       eq,
  output logic       taken
);
  assign taken = (cond == BR_ALWAYS) | (cond == BR_LT & lt) | (cond == BR_GE & ~lt) |
                 (cond == BR_EQ & eq) | (cond == BR_NE & ~eq);
endmodule

// File: rtl/branch_flag_ctrl.sv
// branch_flag_ctrl: resolves conditional branches from the ALU compare flag and owns the pc
// Ports: clk, rst_n (async active-low); stall; decode side br_valid/br_ready/br_cond/
// br_target/br_link; ALU side flag_valid/flag_mask/zero_flag; fetch side pc/flush;
// status taken/link_we/link_addr/busy/flag_err.
// Option BRANCH_FLAG_CHECK_EN: flags malformed masks and reserved conds on sticky flag_err.
module branch_flag_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            br_link,
  input  logic            flag_valid,
  input  logic [15:0]     flag_mask,
  input  logic            zero_flag,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            taken,
  output logic            link_we,
  output logic [PC_W-1:0] link_addr,
  output logic            busy,
  output logic            flag_err
);
  state_t state, nxt;
  logic [2:0] cond, cnt;
  logic [PC_W-1:0] tgt, bpc;
  logic lnk, lt, eq, cond_taken, res_taken;
  branch_cond_eval u_eval (.cond(cond), .lt(lt), .eq(eq), .taken(cond_taken));
`ifdef BRANCH_FLAG_CHECK_EN
  logic bad, err;
  assign res_taken = cond_taken & ~bad;
  assign flag_err = err;
`else
  logic unused_mask;
  assign unused_mask = ^flag_mask[14:0];
  assign res_taken = cond_taken;
  assign flag_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == S_IDLE && br_valid) nxt = br_cond == BR_ALWAYS ? S_RESOLVE : S_WAIT;
    if (state == S_WAIT && flag_valid) nxt = S_RESOLVE;
    if (state == S_RESOLVE) nxt = res_taken ? S_FLUSH : S_IDLE;
    if (state == S_FLUSH && cnt == 3'd0) nxt = S_IDLE;
    br_ready = state == S_IDLE;
    busy = state != S_IDLE;
    flush = state == S_FLUSH;
    taken = state == S_RESOLVE && res_taken;
    link_we = taken && lnk;
    link_addr = state == S_RESOLVE ? bpc + PC_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      bpc <= '0;
      tgt <= '0;
      cond <= '0;
      lnk <= 1'b0;
      lt <= 1'b0;
      eq <= 1'b0;
      cnt <= '0;
`ifdef BRANCH_FLAG_CHECK_EN
      bad <= 1'b0;
      err <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE) begin
        if (br_valid) begin
          cond <= br_cond;
          tgt <= br_target;
          lnk <= br_link;
          bpc <= pc;
`ifdef BRANCH_FLAG_CHECK_EN
          bad <= 1'b0;
          err <= err | (br_cond > BR_NE);
`endif
        end else if (!stall) pc <= pc + PC_W'(1);
      end
      if (state == S_WAIT && flag_valid) begin
        lt <= flag_mask[15];
        eq <= zero_flag;
`ifdef BRANCH_FLAG_CHECK_EN
        bad <= !flag_ok(flag_mask);
        err <= err | !flag_ok(flag_mask);
`endif
      end
      if (state == S_RESOLVE) begin
        pc <= res_taken ? tgt : bpc + PC_W'(1);
        cnt <= 3'(FLUSH_CYC - 1);
      end
      if (state == S_FLUSH) cnt <= cnt - 3'd1;
    end
endmodule

// File: tb/tb_branch_flag_ctrl.sv
// tb_branch_flag_ctrl: directed plus randomized branches checked against a spec-level model
module tb_branch_flag_ctrl;
  localparam int FC = 2;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, br_valid = 1'b0, br_link = 1'b0;
  logic flag_valid = 1'b0, zero_flag = 1'b0;
  logic [2:0] br_cond = 3'd0;
  logic [15:0] br_target = 16'h0, flag_mask = 16'h0;
  logic br_ready, flush, taken, link_we, busy, flag_err;
  logic [15:0] pc, link_addr;
  int tests = 0, fails = 0;
  logic [15:0] mpc = 16'h0;
  logic merr = 1'b0;
  branch_flag_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target), .br_link(br_link), .flag_valid(flag_valid),
    .flag_mask(flag_mask), .zero_flag(zero_flag), .pc(pc), .flush(flush), .taken(taken),
    .link_we(link_we), .link_addr(link_addr), .busy(busy), .flag_err(flag_err));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stall = 1'($urandom_range(0, 1));
      step();
      if (!stall) mpc = mpc + 16'd1;
      chk("pc_idle", pc, mpc);
      chk("ready_idle", br_ready, 1);
    end
    stall = 1'b0;
  endtask
  // Expected decision: the flag says X<Y when it is all-ones (top bit without the check).
  function automatic logic ref_taken(input logic [2:0] c, input logic [15:0] m, input logic z);
    logic x_lt_y;
    x_lt_y = m[15];
    case (c)
      3'd0: return 1'b1;
      3'd1: return x_lt_y;
      3'd2: return !x_lt_y;
      3'd3: return z;
      3'd4: return !z;
      default: return 1'b0;
    endcase
  endfunction
  task automatic branch(input logic [2:0] c, input logic [15:0] t, input logic l,
                        input logic [15:0] m, input logic z, input int d);
    logic [15:0] b, nb;
    logic exp, mal;
    b = mpc;
    nb = b + 16'd1;
    mal = !(m == 16'h0000 || m == 16'hFFFF);
    exp = ref_taken(c, m, z);
`ifdef BRANCH_FLAG_CHECK_EN
    if (c != 3'd0 && mal) exp = 1'b0;
    if ((c != 3'd0 && mal) || c > 3'd4) merr = 1'b1;
`endif
    chk("ready_pre", br_ready, 1);
    br_valid = 1'b1; br_cond = c; br_target = t; br_link = l;
    flag_valid = 1'($urandom_range(0, 1)); flag_mask = ~m; zero_flag = ~z;
    stall = 1'($urandom_range(0, 1));
    step();
    br_valid = 1'b0; flag_valid = 1'b0; stall = 1'b0;
    chk("busy_acc", busy, 1);
    chk("ready_busy", br_ready, 0);
    chk("pc_hold_acc", pc, b);
    if (c != 3'd0) begin
      for (int i = 0; i < d; i++) begin
        step();
        chk("pc_hold_wait", pc, b);
        chk("taken_wait", taken, 0);
      end
      flag_valid = 1'b1; flag_mask = m; zero_flag = z;
      step();
      flag_valid = 1'b0;
    end
    chk("taken", taken, exp);
    chk("link_we", link_we, exp & l);
    if (exp && l) chk("link_addr", link_addr, nb);
    chk("flush_res", flush, 0);
    step();
    chk("taken_pulse", taken, 0);
    chk("link_we_pulse", link_we, 0);
    if (exp) begin
      mpc = t;
      for (int i = 0; i < FC; i++) begin
        chk("flush", flush, 1);
        chk("pc_flush", pc, t);
        stall = 1'($urandom_range(0, 1));
        step();
      end
      stall = 1'b0;
    end else mpc = nb;
    chk("flush_end", flush, 0);
    chk("busy_end", busy, 0);
    chk("pc_after", pc, mpc);
    chk("flag_err", flag_err, merr);
  endtask
  initial begin
    logic [2:0] c;
    logic [15:0] m;
    int sel;
    repeat (2) step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0);
    chk("rst_taken", taken, 0);
    chk("rst_link_we", link_we, 0);
    chk("rst_link_addr", link_addr, 0);
    chk("rst_flag_err", flag_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_pc0", pc, 16'h0000);
    chk("t1_ready", br_ready, 1);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("t1_pc", pc, 32'(i));
      chk("t1_busy", busy, 0);
      chk("t1_ready", br_ready, 1);
    end
    mpc = 16'd4;
    branch(3'd0, 16'h0010, 1'b0, 16'h0000, 1'b0, 0);
    branch(3'd1, 16'h0200, 1'b0, 16'hFFFF, 1'b0, 1);
    chk("t2_pc", pc, 16'h0200);
    branch(3'd0, 16'h0010, 1'b0, 16'h0000, 1'b0, 0);
    branch(3'd2, 16'h0200, 1'b1, 16'hFFFF, 1'b0, 1);
    chk("t3_pc", pc, 16'h0011);
    branch(3'd0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 0);
    branch(3'd0, 16'h0040, 1'b1, 16'h0000, 1'b0, 0);
    chk("t4_pc", pc, 16'h0040);
    br_valid = 1'b1; br_cond = 3'd1; br_target = 16'h1234; br_link = 1'b0;
    step();
    br_valid = 1'b0;
    step();
    chk("t5_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pc", pc, 16'h0000);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flag_valid = 1'b1; flag_mask = 16'hFFFF;
    step();
    flag_valid = 1'b0;
    mpc = 16'h0001;
    merr = 1'b0;
    chk("t5_late_flag_busy", busy, 0);
    chk("t5_late_flag_taken", taken, 0);
    chk("t5_pc", pc, mpc);
    idle(2);
    repeat (40) begin
      idle($urandom_range(0, 3));
      c = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 4);
      m = sel < 2 ? 16'hFFFF : sel < 4 ? 16'h0000 : 16'($urandom);
      branch(c, 16'($urandom), 1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end
`ifdef BRANCH_FLAG_CHECK_EN
    branch(3'd3, 16'h0777, 1'b0, 16'h00F0, 1'b1, 0);
    idle(3);
    chk("t6_sticky", flag_err, 1);
`else
    branch(3'd3, 16'h0777, 1'b0, 16'h00F0, 1'b1, 0);
    chk("t6_no_check", flag_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
